reg_op_sequencer: RTL

- Command-side master for the 4-bit func-controlled datapath register.
- Accepts one high-level command per handshake and expands it into a cycle-by-cycle stream of func codes and load data that drive a register instance.
- Keeps a shadow copy of the target register's contents. Verification compares it against the real register; control logic uses it for status.

---
 rtl/reg_op_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// Command sequencer for the 4-bit func-controlled register: expands one accepted
// command into per-cycle func/data codes and keeps a shadow of the register contents.
module reg_op_sequencer #(
  parameter int COUNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_data,
  input  logic [COUNT_W-1:0] cmd_count,
  output logic               cmd_ready,
  output logic [3:0]         func,
  output logic [3:0]         data_out,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [3:0]         shadow
);

  localparam logic [3:0] F_HOLD  = 4'b0000;
  localparam logic [3:0] F_LOAD  = 4'b0001;
  localparam logic [3:0] F_CLEAR = 4'b0010;
  localparam logic [3:0] F_SHR   = 4'b0011;
  localparam logic [3:0] F_SHL   = 4'b0100;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_CLEAR    = 3'd2;
  localparam logic [2:0] OP_SHR      = 3'd3;
  localparam logic [2:0] OP_SHL      = 3'd4;
  localparam logic [2:0] OP_LOAD_SHR = 3'd5;
  localparam logic [2:0] OP_LOAD_SHL = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         func_q, func_d;
  logic [3:0]         data_q, data_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [COUNT_W-1:0] counter_q, counter_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [2:0]         op_q, op_d;
  logic               error_q, error_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      func_q    <= F_HOLD;
      data_q    <= 4'b0000;
      shadow_q  <= 4'b0000;
      counter_q <= '0;
      len_q     <= '0;
      op_q      <= OP_NOP;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      data_q    <= data_d;
      shadow_q  <= shadow_d;
      counter_q <= counter_d;
      len_q     <= len_d;
      op_q      <= op_d;
      error_q   <= error_d;
    end
  end

  // Shadow follows the func already on the bus, exactly as the target register does.
  always_comb begin
    shadow_d = shadow_q;
    case (func_q)
      F_LOAD:  shadow_d = data_q;
      F_CLEAR: shadow_d = 4'b0000;
      F_SHR:   shadow_d = {1'b0, shadow_q[3:1]};
      F_SHL:   shadow_d = {shadow_q[2:0], 1'b0};
      default: shadow_d = shadow_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    func_d    = F_HOLD;
    data_d    = data_q;
    counter_d = counter_q;
    len_d     = len_q;
    op_d      = op_q;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          len_d = cmd_count;
          case (cmd_op)
            OP_LOAD, OP_LOAD_SHR, OP_LOAD_SHL: begin
              state_d = S_LOAD;
              func_d  = F_LOAD;
              data_d  = cmd_data;
            end
            OP_CLEAR: begin
              state_d = S_CLEAR;
              func_d  = F_CLEAR;
            end
            OP_SHR, OP_SHL: begin
              if (cmd_count != '0) begin
                state_d   = S_SHIFT;
                func_d    = (cmd_op == OP_SHR) ? F_SHR : F_SHL;
                counter_d = cmd_count - COUNT_W'(1);
              end else begin
                state_d = S_DONE;
              end
            end
            OP_NOP: state_d = S_DONE;
            default: begin
              state_d = S_DONE;
              error_d = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        if ((op_q == OP_LOAD_SHR || op_q == OP_LOAD_SHL) && len_q != '0) begin
          state_d   = S_SHIFT;
          func_d    = (op_q == OP_LOAD_SHR) ? F_SHR : F_SHL;
          counter_d = len_q - COUNT_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_CLEAR: state_d = S_DONE;
      S_SHIFT: begin
        // The counter holds the shifts still owed after the one now on the bus.
        if (counter_q == '0) begin
          state_d = S_DONE;
        end else begin
          counter_d = counter_q - COUNT_W'(1);
          func_d    = func_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        error_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign func      = func_q;
  assign data_out  = data_q;
  assign shadow    = shadow_q;

endmodule
